// File: rtl/aquila_dbus_router.sv
// aquila_dbus_router: routes the Aquila core data port to one of N_PORTS
// memory-mapped targets by decoding the top SEG_BITS address bits. Exactly one
// transaction may be outstanding. Unmapped addresses and (optionally) hung
// targets are answered with a one-cycle bus-error response, counted in
// err_count_o and recorded in err_addr_o.
// Optional feature macro: DBUS_TIMEOUT_EN builds the WAIT-state watchdog.
module aquila_dbus_router #(
    parameter int                          XLEN           = 32,
    parameter int                          N_PORTS        = 4,
    parameter int                          SEG_BITS       = 4,
    parameter logic [N_PORTS*SEG_BITS-1:0] PORT_SEG       = {4'hF, 4'hC, 4'h8, 4'h0},
    parameter int                          DEFAULT_PORT   = 1,
    parameter int                          TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    p_strobe_i,
    input  logic [XLEN-1:0]         p_addr_i,
    input  logic                    p_rw_i,
    input  logic [XLEN/8-1:0]       p_byte_enable_i,
    input  logic [XLEN-1:0]         p_data_i,
    output logic [XLEN-1:0]         p_data_o,
    output logic                    p_ready_o,
    output logic                    p_error_o,
    output logic [N_PORTS-1:0]      s_strobe_o,
    output logic [N_PORTS-1:0]      s_rw_o,
    output logic [XLEN-1:0]         s_addr_o,
    output logic [XLEN/8-1:0]       s_byte_enable_o,
    output logic [XLEN-1:0]         s_data_o,
    input  logic [N_PORTS*XLEN-1:0] s_data_i,
    input  logic [N_PORTS-1:0]      s_ready_i,
    output logic [15:0]             err_count_o,
    output logic [XLEN-1:0]         err_addr_o
);

    localparam int SEL_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } state_t;

    state_t             state, state_n;
    logic [SEL_W-1:0]   sel_r;
    logic [XLEN-1:0]    addr_r;
    logic [SEG_BITS-1:0] seg;
    logic               mapped;
    logic [SEL_W-1:0]   dec_port;
    logic               sel_ready;
    logic [XLEN-1:0]    sel_data;
    logic               issue;
    logic               wd_expire;

    assign seg       = p_addr_i[XLEN-1 -: SEG_BITS];
    assign sel_ready = s_ready_i[sel_r];
    assign sel_data  = s_data_i[sel_r*XLEN +: XLEN];

    // Segment decode: scan downwards so the lowest matching port wins, then fall back to the default port.
    always_comb begin
        logic             hit;
        logic [SEL_W-1:0] hit_idx;
        hit      = 1'b0;
        hit_idx  = '0;
        mapped   = 1'b0;
        dec_port = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (seg == PORT_SEG[k*SEG_BITS +: SEG_BITS]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
        if (hit) begin
            mapped   = 1'b1;
            dec_port = hit_idx;
        end else if (DEFAULT_PORT < N_PORTS) begin
            mapped   = 1'b1;
            dec_port = SEL_W'(DEFAULT_PORT);
        end
    end

`ifdef DBUS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // The last allowed WAIT cycle sees the counter at TIMEOUT_CYCLES-1; a ready in that cycle still wins.
    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts WAIT cycles that pass without the selected target answering.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt <= '0;
        end else if (issue) begin
            wd_cnt <= '0;
        end else if (state == WAIT && !sel_ready) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // Next-state and all core/target outputs; targets see a request only in the issuing IDLE cycle.
    always_comb begin
        state_n         = state;
        issue           = 1'b0;
        p_data_o        = '0;
        p_ready_o       = 1'b0;
        p_error_o       = 1'b0;
        s_strobe_o      = '0;
        s_rw_o          = '0;
        s_addr_o        = '0;
        s_byte_enable_o = '0;
        s_data_o        = '0;
        case (state)
            IDLE: begin
                if (p_strobe_i) begin
                    if (mapped) begin
                        issue                = 1'b1;
                        s_strobe_o[dec_port] = 1'b1;
                        s_rw_o[dec_port]     = p_rw_i;
                        s_addr_o             = p_addr_i;
                        s_byte_enable_o      = p_byte_enable_i;
                        s_data_o             = p_data_i;
                        state_n              = WAIT;
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            WAIT: begin
                p_data_o  = sel_data;
                p_ready_o = sel_ready;
                if (sel_ready) begin
                    state_n = IDLE;
                end else if (wd_expire) begin
                    state_n = ERR;
                end
            end
            ERR: begin
                p_ready_o = 1'b1;
                p_error_o = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register plus the request context captured when a strobe is accepted in IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            sel_r  <= '0;
            addr_r <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && p_strobe_i) begin
                sel_r  <= dec_port;
                addr_r <= p_addr_i;
            end
        end
    end

    // Error bookkeeping is updated as the ERR response is delivered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_count_o <= '0;
            err_addr_o  <= '0;
        end else if (state == ERR) begin
            err_addr_o <= addr_r;
            if (err_count_o != 16'hFFFF) begin
                err_count_o <= err_count_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_aquila_dbus_router.sv
// Testbench for aquila_dbus_router: two instances (default port mapped / unmapped)
// share one stimulus stream and are compared every cycle against a
// transaction-level model; directed scenarios add literal expectations.
module tb_aquila_dbus_router;

    localparam int XLEN  = 32;
    localparam int NP    = 4;
    localparam int TO    = 16;
    localparam int DEF_A = 1;
    localparam int DEF_B = 4;
`ifdef DBUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            p_strobe;
    logic [31:0]     p_addr;
    logic            p_rw;
    logic [3:0]      p_be;
    logic [31:0]     p_wdata;
    logic [127:0]    s_rdata;
    logic [3:0]      s_ready;

    logic [31:0]     o_pdata [2];
    logic            o_pready [2];
    logic            o_perr [2];
    logic [3:0]      o_sstb [2];
    logic [3:0]      o_srw [2];
    logic [31:0]     o_saddr [2];
    logic [3:0]      o_sbe [2];
    logic [31:0]     o_sdata [2];
    logic [15:0]     o_ecnt [2];
    logic [31:0]     o_eaddr [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Transaction-level model state, one slot per instance.
    bit          m_busy [2];
    bit          m_perr [2];
    int          m_sel [2];
    int          m_wait [2];
    logic [31:0] m_addr [2];
    logic [15:0] m_ecnt [2];
    logic [31:0] m_eaddr [2];

    always #5 clk = ~clk;

    aquila_dbus_router #(.XLEN(XLEN), .N_PORTS(NP), .SEG_BITS(4), .PORT_SEG(16'hFC80),
                         .DEFAULT_PORT(DEF_A), .TIMEOUT_CYCLES(TO)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .p_strobe_i(p_strobe), .p_addr_i(p_addr), .p_rw_i(p_rw),
        .p_byte_enable_i(p_be), .p_data_i(p_wdata), .p_data_o(o_pdata[0]), .p_ready_o(o_pready[0]),
        .p_error_o(o_perr[0]), .s_strobe_o(o_sstb[0]), .s_rw_o(o_srw[0]), .s_addr_o(o_saddr[0]),
        .s_byte_enable_o(o_sbe[0]), .s_data_o(o_sdata[0]), .s_data_i(s_rdata), .s_ready_i(s_ready),
        .err_count_o(o_ecnt[0]), .err_addr_o(o_eaddr[0]));

    aquila_dbus_router #(.XLEN(XLEN), .N_PORTS(NP), .SEG_BITS(4), .PORT_SEG(16'hFC80),
                         .DEFAULT_PORT(DEF_B), .TIMEOUT_CYCLES(TO)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .p_strobe_i(p_strobe), .p_addr_i(p_addr), .p_rw_i(p_rw),
        .p_byte_enable_i(p_be), .p_data_i(p_wdata), .p_data_o(o_pdata[1]), .p_ready_o(o_pready[1]),
        .p_error_o(o_perr[1]), .s_strobe_o(o_sstb[1]), .s_rw_o(o_srw[1]), .s_addr_o(o_saddr[1]),
        .s_byte_enable_o(o_sbe[1]), .s_data_o(o_sdata[1]), .s_data_i(s_rdata), .s_ready_i(s_ready),
        .err_count_o(o_ecnt[1]), .err_addr_o(o_eaddr[1]));

    function automatic int defOf(input int d);
        return (d == 0) ? DEF_A : DEF_B;
    endfunction

    // Target index for an address, or -1 when the request is unmapped.
    function automatic int route(input logic [31:0] a, input int def);
        int seg_of [4] = '{0, 8, 12, 15};
        for (int k = 0; k < 4; k++) begin
            if (int'(a[31:28]) == seg_of[k]) return k;
        end
        return (def < 4) ? def : -1;
    endfunction

    task automatic checkOutput(input string name, input int d, input logic [31:0] got,
                               input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, got, exp);
        end
    endtask

    task automatic compareOne(input int d);
        logic [31:0] e_pdata, e_saddr, e_sdata;
        logic        e_rdy, e_err;
        logic [3:0]  e_stb, e_rw, e_be;
        int          t;
        e_pdata = '0; e_saddr = '0; e_sdata = '0;
        e_rdy = 1'b0; e_err = 1'b0;
        e_stb = '0; e_rw = '0; e_be = '0;
        if (m_perr[d]) begin
            e_rdy = 1'b1;
            e_err = 1'b1;
        end else if (m_busy[d]) begin
            e_pdata = s_rdata[m_sel[d]*32 +: 32];
            e_rdy   = s_ready[m_sel[d]];
        end else if (p_strobe) begin
            t = route(p_addr, defOf(d));
            if (t >= 0) begin
                e_stb[t] = 1'b1;
                e_rw[t]  = p_rw;
                e_saddr  = p_addr;
                e_sdata  = p_wdata;
                e_be     = p_be;
            end
        end
        checkOutput("p_data",  d, o_pdata[d],        e_pdata);
        checkOutput("p_ready", d, 32'(o_pready[d]),  32'(e_rdy));
        checkOutput("p_error", d, 32'(o_perr[d]),    32'(e_err));
        checkOutput("s_strobe", d, 32'(o_sstb[d]),   32'(e_stb));
        checkOutput("s_rw",    d, 32'(o_srw[d]),     32'(e_rw));
        checkOutput("s_addr",  d, o_saddr[d],        e_saddr);
        checkOutput("s_data",  d, o_sdata[d],        e_sdata);
        checkOutput("s_be",    d, 32'(o_sbe[d]),     32'(e_be));
        checkOutput("err_count", d, 32'(o_ecnt[d]),  32'(m_ecnt[d]));
        checkOutput("err_addr", d, o_eaddr[d],       m_eaddr[d]);
    endtask

    task automatic modelStep(input int d);
        int t;
        if (rst) begin
            m_busy[d] = 1'b0; m_perr[d] = 1'b0; m_sel[d] = 0; m_wait[d] = 0;
            m_addr[d] = '0; m_ecnt[d] = '0; m_eaddr[d] = '0;
        end else if (m_perr[d]) begin
            if (m_ecnt[d] != 16'hFFFF) m_ecnt[d] = m_ecnt[d] + 16'd1;
            m_eaddr[d] = m_addr[d];
            m_perr[d]  = 1'b0;
        end else if (m_busy[d]) begin
            if (s_ready[m_sel[d]]) begin
                m_busy[d] = 1'b0;
            end else begin
                m_wait[d]++;
                if (TO_EN && m_wait[d] >= TO) begin
                    m_busy[d] = 1'b0;
                    m_perr[d] = 1'b1;
                end
            end
        end else if (p_strobe) begin
            m_addr[d] = p_addr;
            t = route(p_addr, defOf(d));
            if (t >= 0) begin
                m_busy[d] = 1'b1;
                m_sel[d]  = t;
                m_wait[d] = 0;
            end else begin
                m_perr[d] = 1'b1;
            end
        end
    endtask

    // Advance the model on each clock edge with the inputs the DUTs sampled.
    always @(posedge clk) begin
        cyc++;
        modelStep(0);
        modelStep(1);
        if (rst) chk_en = 1'b1;
    end

    // Compare both instances against the model mid-cycle, once the model is synchronised.
    always @(negedge clk) begin
        if (chk_en) begin
            compareOne(0);
            compareOne(1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic stb, input logic [31:0] addr, input logic rw,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input logic [3:0] rdy);
        p_strobe = stb;
        p_addr   = addr;
        p_rw     = rw;
        p_be     = be;
        p_wdata  = wdata;
        s_ready  = rdy;
    endtask

    initial begin
        logic [3:0] nib;
        rst     = 1'b1;
        s_rdata = '0;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
        tick; tick;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_err_count", 0, 32'(o_ecnt[0]), 32'h0);
        checkOutput("rst_err_addr",  1, o_eaddr[1],     32'h0);
        checkOutput("rst_p_ready",   0, 32'(o_pready[0]), 32'h0);

        // TCM read
        tick;
        applyStimulus(1'b1, 32'h0000_0040, 1'b0, 4'hF, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("tcm_s_strobe", 0, 32'(o_sstb[0]), 32'h1);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'b0001);
        s_rdata[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("tcm_p_ready", 0, 32'(o_pready[0]), 32'h1);
        checkOutput("tcm_p_data",  0, o_pdata[0],       32'hDEAD_BEEF);
        checkOutput("tcm_p_error", 0, 32'(o_perr[0]),   32'h0);

        // Device write, stray port 3 ready ignored
        tick;
        applyStimulus(1'b1, 32'hC000_0008, 1'b1, 4'b0011, 32'h1234_5678, 4'h0);
        @(negedge clk);
        checkOutput("dev_s_strobe", 0, 32'(o_sstb[0]), 32'b0100);
        checkOutput("dev_s_rw",     0, 32'(o_srw[0]),  32'b0100);
        checkOutput("dev_s_data",   0, o_sdata[0],     32'h1234_5678);
        checkOutput("dev_s_be",     0, 32'(o_sbe[0]),  32'b0011);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'b1000);
        @(negedge clk);
        checkOutput("dev_stray_ready", 0, 32'(o_pready[0]), 32'h0);
        tick;
        s_ready = 4'b0100;
        @(negedge clk);
        checkOutput("dev_p_ready", 0, 32'(o_pready[0]), 32'h1);

        // Unmapped address (instance B errors, instance A uses default port 1)
        tick;
        applyStimulus(1'b1, 32'h5000_0000, 1'b0, 4'hF, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("unm_s_strobe", 1, 32'(o_sstb[1]), 32'h0);
        checkOutput("def_s_strobe", 0, 32'(o_sstb[0]), 32'b0010);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'b0010);
        s_rdata[63:32] = 32'hA5A5_A5A5;
        @(negedge clk);
        checkOutput("unm_p_ready", 1, 32'(o_pready[1]), 32'h1);
        checkOutput("unm_p_error", 1, 32'(o_perr[1]),   32'h1);
        checkOutput("unm_p_data",  1, o_pdata[1],       32'h0);
        checkOutput("def_p_data",  0, o_pdata[0],       32'hA5A5_A5A5);
        checkOutput("def_p_error", 0, 32'(o_perr[0]),   32'h0);
        tick;
        s_ready = 4'h0;
        @(negedge clk);
        checkOutput("unm_err_count", 1, 32'(o_ecnt[1]), 32'h1);
        checkOutput("unm_err_addr",  1, o_eaddr[1],     32'h5000_0000);

        // Timeout on port 1, late ready ignored
        tick;
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, 4'hF, 32'h0, 4'h0);
        for (int c = 1; c <= 17; c++) begin
            tick;
            applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
        end
        @(negedge clk);
        checkOutput("to_p_ready", 0, 32'(o_pready[0]), 32'(TO_EN));
        checkOutput("to_p_error", 0, 32'(o_perr[0]),   32'(TO_EN));
        for (int c = 18; c <= 20; c++) tick;
        s_ready = 4'b0010;
        @(negedge clk);
        checkOutput("to_late_ready", 0, 32'(o_pready[0]), 32'(!TO_EN));
        tick;
        s_ready = 4'h0;
        @(negedge clk);
        checkOutput("to_err_count", 0, 32'(o_ecnt[0]), TO_EN ? 32'h1 : 32'h0);

        // Ready in the final WAIT cycle wins over the timeout
        tick;
        applyStimulus(1'b1, 32'h8000_0000, 1'b0, 4'hF, 32'h0, 4'h0);
        for (int c = 1; c <= 16; c++) begin
            tick;
            applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, (c == 16) ? 4'b0010 : 4'h0);
        end
        @(negedge clk);
        checkOutput("win_p_ready", 0, 32'(o_pready[0]), 32'h1);
        checkOutput("win_p_error", 0, 32'(o_perr[0]),   32'h0);
        tick;
        s_ready = 4'h0;
        @(negedge clk);
        checkOutput("win_err_count", 0, 32'(o_ecnt[0]), TO_EN ? 32'h1 : 32'h0);

        // Reset in the middle of a transaction
        tick;
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 4'h0);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        s_ready = 4'b0001;
        @(negedge clk);
        checkOutput("mid_rst_p_ready",   0, 32'(o_pready[0]), 32'h0);
        checkOutput("mid_rst_p_data",    0, o_pdata[0],       32'h0);
        checkOutput("mid_rst_err_count", 1, 32'(o_ecnt[1]),   32'h0);
        tick;
        applyStimulus(1'b1, 32'h0000_0200, 1'b0, 4'hF, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("mid_rst_new_strobe", 0, 32'(o_sstb[0]), 32'b0001);
        tick;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'b0001);
        @(negedge clk);
        checkOutput("mid_rst_new_ready", 0, 32'(o_pready[0]), 32'h1);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick;
            case ($urandom_range(0, 4))
                0: nib = 4'h0;
                1: nib = 4'h8;
                2: nib = 4'hC;
                3: nib = 4'hF;
                default: nib = 4'($urandom_range(0, 15));
            endcase
            applyStimulus(($urandom_range(0, 2) == 0), {nib, 28'($urandom)}, 1'($urandom),
                          4'($urandom), $urandom,
                          {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)});
            s_rdata = {$urandom, $urandom, $urandom, $urandom};
            rst = ($urandom_range(0, 299) == 0);
        end
        tick;
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
        tick;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
